timer_arbiter: RTL

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter_pkg.sv | 23 ++
 rtl/timer_arbiter_rr_pick.sv | 26 ++
 rtl/timer_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/timer_arbiter_pkg.sv
// timer_arbiter_pkg: shared timer constants, arbiter state encodings and helpers
package timer_arbiter_pkg;

    localparam int TIMR_W = 16;
    localparam int TIMR_MAX_C = 8;
    localparam int ARB_WDOG_MAX_C = TIMR_MAX_C + 8;

    typedef enum logic [1:0] {
        ARB_IDLE_S = 2'd0,
        ARB_ARM_S  = 2'd1,
        ARB_WAIT_S = 2'd2,
        ARB_DONE_S = 2'd3
    } arb_state_t;

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             valid
);

    int k;

    // Walk from farthest to nearest so the slot at ptr wins last.
    always_comb begin
        gnt = '0;
        k = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N_REQ;
            if (req[k]) gnt = N_REQ'(1) << k;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one external timer with a WAIT watchdog
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WDOG_MAX = ARB_WDOG_MAX_C
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GRANT,
    output logic [N_REQ-1:0] DONE,
    output logic             ERR,
    output logic             BUSY,
    output logic             TMR_START,
    input  logic             TMR_PULSE
);

    localparam int PW = $clog2(N_REQ);
    localparam int WW = $clog2(WDOG_MAX);

    arb_state_t state, next_state;
    logic [N_REQ-1:0] pending, owner, pick, clr;
    logic [PW-1:0] ptr, owner_idx;
    logic [WW-1:0] wdog;
    logic valid, wd_exp;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req(pending | REQ),
        .ptr(ptr),
        .gnt(pick),
        .valid(valid)
    );

    // A coincident TMR_PULSE beats the watchdog.
    assign wd_exp = state == ARB_WAIT_S && wdog == WW'(WDOG_MAX - 1) && !TMR_PULSE;
    assign owner_idx = PW'(oh2idx(8'(owner)));
    assign clr = (state == ARB_DONE_S || wd_exp) ? owner : '0;

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= ARB_IDLE_S;
        else state <= next_state;
    end

    always_comb begin
        next_state = ARB_IDLE_S;
        case (state)
            ARB_IDLE_S: next_state = valid ? ARB_ARM_S : ARB_IDLE_S;
            ARB_ARM_S:  next_state = ARB_WAIT_S;
            ARB_WAIT_S: next_state = TMR_PULSE ? ARB_DONE_S : wd_exp ? ARB_IDLE_S : ARB_WAIT_S;
            default:    next_state = ARB_IDLE_S;
        endcase
    end

    always_comb begin
        BUSY = state != ARB_IDLE_S;
        GRANT = BUSY ? owner : '0;
        DONE = state == ARB_DONE_S ? owner : '0;
        TMR_START = state == ARB_ARM_S;
        ERR = wd_exp;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pending <= '0;
            owner <= '0;
            ptr <= '0;
            wdog <= '0;
        end else begin
            pending <= (pending & ~clr) | REQ;
            wdog <= state == ARB_WAIT_S ? wdog + 1'b1 : '0;
            if (state == ARB_IDLE_S && valid) owner <= pick;
            if (state == ARB_DONE_S || wd_exp)
                ptr <= owner_idx == PW'(N_REQ - 1) ? '0 : owner_idx + 1'b1;
        end
    end

endmodule
